// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and ALU operation set for the single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_PRIV    = 3'b000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << b[4:0];
      ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   return {31'b0, a < b};
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_PASS_B: return b;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hardwired to zero.
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv32i_single_cycle_cpu.sv
// Single-cycle RV32I core with private instruction ROM and byte-addressed data RAM.
module rv32i_single_cycle_cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_BYTES = 1024,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst
);
  import rv32i_pkg::*;

  localparam int unsigned IA = $clog2(IMEM_WORDS);
  localparam int unsigned DA = $clog2(DMEM_BYTES);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [7:0]  dmem [0:DMEM_BYTES-1];
  logic [31:0] pc_q;
  logic        halted;

  logic [31:0] instr, pc_plus4, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr    = ({2'b00, pc_q[31:2]} < IMEM_WORDS) ? imem[pc_q[IA+1:2]] : 32'h0000_0013;
  assign pc_plus4 = pc_q + 32'd4;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_y, wb_data, load_data, next_pc;
  logic        reg_we, mem_we, halt_now, link, is_load, br_taken;
  alu_op_t     alu_op, op_dec;

  rv32i_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we && !halted),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .waddr  (rd),
    .wdata  (wb_data),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    op_dec = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: op_dec = (opcode == OP_REG && instr[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op_dec = ALU_SLL;
      F3_SLT:     op_dec = ALU_SLT;
      F3_SLTU:    op_dec = ALU_SLTU;
      F3_XOR:     op_dec = ALU_XOR;
      F3_SR:      op_dec = instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:      op_dec = ALU_OR;
      F3_AND:     op_dec = ALU_AND;
      default:    op_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_a    = rs1_val;
    alu_b    = rs2_val;
    alu_op   = ALU_ADD;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    halt_now = 1'b0;
    link     = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      OP_LUI:    begin alu_op = ALU_PASS_B; alu_b = imm_u; reg_we = 1'b1; end
      OP_AUIPC:  begin alu_a = pc_q; alu_b = imm_u; reg_we = 1'b1; end
      OP_JAL:    begin reg_we = 1'b1; link = 1'b1; end
      OP_JALR:   begin alu_b = imm_i; reg_we = 1'b1; link = 1'b1; end
      OP_BRANCH: ;
      OP_LOAD:   begin alu_b = imm_i; reg_we = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin alu_b = imm_s; mem_we = 1'b1; end
      OP_IMM:    begin alu_b = imm_i; alu_op = op_dec; reg_we = 1'b1; end
      OP_REG:    begin alu_op = op_dec; reg_we = 1'b1; end
      OP_FENCE:  ;
      // ECALL and EBREAK differ only in imm[0]; CSR forms fall through as NOPs
      OP_SYSTEM: halt_now = (funct3 == F3_PRIV) && (instr[31:21] == 11'd0);
      default:   ;
    endcase
  end

  assign alu_y = alu_eval(alu_op, alu_a, alu_b);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (opcode == OP_JAL)                     next_pc = pc_q + imm_j;
    else if (opcode == OP_JALR)               next_pc = alu_y & ~32'd1;
    else if (opcode == OP_BRANCH && br_taken) next_pc = pc_q + imm_b;
  end

  logic [DA-1:0] daddr, wa0, wa1, wa2, wa3;
  logic [31:0]   rword;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;

  assign daddr = alu_y[DA-1:0];
  assign wa0   = {daddr[DA-1:2], 2'b00};
  assign wa1   = {daddr[DA-1:2], 2'b01};
  assign wa2   = {daddr[DA-1:2], 2'b10};
  assign wa3   = {daddr[DA-1:2], 2'b11};
  assign rword = {dmem[wa3], dmem[wa2], dmem[wa1], dmem[wa0]};
  assign lbyte = 8'(rword >> {daddr[1:0], 3'b000});
  assign lhalf = daddr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    case (funct3)
      F3_LB:   load_data = {{24{lbyte[7]}}, lbyte};
      F3_LH:   load_data = {{16{lhalf[15]}}, lhalf};
      F3_LW:   load_data = rword;
      F3_LBU:  load_data = {24'b0, lbyte};
      F3_LHU:  load_data = {16'b0, lhalf};
      default: load_data = rword;
    endcase
  end

  assign wb_data = link ? pc_plus4 : (is_load ? load_data : alu_y);

  // RAM keeps its contents across reset; reset only suppresses a store in flight
  always_ff @(posedge clk) begin
    if (!rst && !halted && mem_we) begin
      case (funct3)
        F3_SB: dmem[daddr] <= rs2_val[7:0];
        F3_SH: begin
          if (daddr[1]) begin
            dmem[wa2] <= rs2_val[7:0];
            dmem[wa3] <= rs2_val[15:8];
          end else begin
            dmem[wa0] <= rs2_val[7:0];
            dmem[wa1] <= rs2_val[15:8];
          end
        end
        F3_SW: begin
          dmem[wa0] <= rs2_val[7:0];
          dmem[wa1] <= rs2_val[15:8];
          dmem[wa2] <= rs2_val[23:16];
          dmem[wa3] <= rs2_val[31:24];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt_now) halted <= 1'b1;
      else          pc_q   <= next_pc & ~32'd3;
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle_cpu.sv
// Program-level bench: loads small RV32I programs into the ROM and scores architectural state.
module tb_rv32i_single_cycle_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_single_cycle_cpu #(
    .IMEM_WORDS (256),
    .DMEM_BYTES (1024),
    .IMEM_INIT  ("")
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_IMM = 7'b0010011, T_REG = 7'b0110011;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum int {K_REG, K_PC, K_HALT, K_MEMW, K_MEMB} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int unsigned idx;
    logic [31:0] exp;
  } exp_t;
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] prog[$];
  int          total = 0;
  int          passed = 0;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d);
    return {f7, s2, s1, f3, d, T_REG};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d, logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3);
    return {imm[11:5], s2, s1, f3, imm[4:0], T_ST};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], T_BR};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] d, logic [6:0] op);
    return {imm, d, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, T_JAL};
  endfunction

  function automatic void li(logic [4:0] d, logic [31:0] v);
    logic [31:0] hi;
    hi = v + 32'h800;
    prog.push_back(enc_u(hi[31:12], d, T_LUI));
    prog.push_back(enc_i(v[11:0], d, 3'b000, d, T_IMM));
  endfunction

  function automatic void add_vec(string n, logic [31:0] i, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void expect_val(string n, kind_t k, int unsigned idx, logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] observe(kind_t k, int unsigned idx);
    logic [4:0] r;
    logic [9:0] a;
    r = idx[4:0];
    a = idx[9:0];
    case (k)
      K_REG:   return dut.u_rf.regs[r];
      K_PC:    return dut.pc_q;
      K_HALT:  return {31'b0, dut.halted};
      K_MEMW:  return {dut.dmem[a + 10'd3], dut.dmem[a + 10'd2], dut.dmem[a + 10'd1], dut.dmem[a]};
      K_MEMB:  return {24'b0, dut.dmem[a]};
      default: return 'x;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", n, act, exp);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, observe(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.imem[i[7:0]] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
    prog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_to_halt(input string n, input int max_cycles);
    int c;
    c = 0;
    while (!dut.halted && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    chk({n, "_halt"}, {31'b0, dut.halted}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;

    add_vec("add",   enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    add_vec("sub",   enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'h1, 32'hFFFF_FFFF);
    add_vec("sll",   enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'h1, 32'd33, 32'h2);
    add_vec("slt",   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'hFFFF_FFFF, 32'h1, 32'h1);
    add_vec("sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3), 32'hFFFF_FFFF, 32'h1, 32'h0);
    add_vec("xor",   enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    add_vec("or",    enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    add_vec("and",   enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    add_vec("srl",   enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3), 32'h8000_0000, 32'd4, 32'h0800_0000);
    add_vec("sra",   enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3), 32'h8000_0000, 32'd36, 32'hF800_0000);
    add_vec("slti",  enc_i(12'hFFF, 5'd1, 3'b010, 5'd3, T_IMM), 32'hFFFF_FFFE, 32'h0, 32'h1);
    add_vec("sltiu", enc_i(12'hFFF, 5'd1, 3'b011, 5'd3, T_IMM), 32'h5, 32'h0, 32'h1);
    add_vec("xori",  enc_i(12'hFFF, 5'd1, 3'b100, 5'd3, T_IMM), 32'h1234_5678, 32'h0, 32'hEDCB_A987);
    add_vec("srai",  enc_i({7'h20, 5'd31}, 5'd1, 3'b101, 5'd3, T_IMM), 32'h8000_0000, 32'h0, 32'hFFFF_FFFF);
    add_vec("srli",  enc_i({7'h00, 5'd28}, 5'd1, 3'b101, 5'd3, T_IMM), 32'hFFFF_FFFF, 32'h0, 32'h0000_000F);
    add_vec("slli",  enc_i({7'h00, 5'd4}, 5'd1, 3'b001, 5'd3, T_IMM), 32'h0000_000F, 32'h0, 32'h0000_00F0);
    add_vec("andi",  enc_i(12'h0F0, 5'd1, 3'b111, 5'd3, T_IMM), 32'h1234_5678, 32'h0, 32'h0000_0070);
    add_vec("ori",   enc_i(12'h800, 5'd1, 3'b110, 5'd3, T_IMM), 32'h0, 32'h0, 32'hFFFF_F800);
    add_vec("addi",  enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, T_IMM), 32'h8000_0000, 32'h0, 32'h7FFF_FFFF);
    add_vec("lui",   enc_u(20'hABCDE, 5'd3, T_LUI), 32'h0, 32'h0, 32'hABCD_E000);
    add_vec("auipc", enc_u(20'h00001, 5'd3, T_AUIPC), 32'h0, 32'h0, 32'h0000_1010);

    // ALU sequence, PC sequencing after reset, halt freeze
    prog.push_back(enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, T_IMM));
    prog.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd2, T_IMM));
    prog.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3));
    prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4));
    prog.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd5));
    prog.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd0, T_IMM));
    prog.push_back(ECALL);
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd6, T_IMM));
    load_prog();
    expect_val("alu_x3", K_REG, 3, 32'hFFFF_FFF8);
    expect_val("alu_x4", K_REG, 4, 32'h0);
    expect_val("alu_x5", K_REG, 5, 32'hFFFF_FFFF);
    expect_val("alu_x0", K_REG, 0, 32'h0);
    expect_val("halt_pc", K_PC, 0, 32'd24);
    expect_val("halt_no_wr", K_REG, 6, 32'h0);
    do_reset();
    chk("pc_reset", dut.pc_q, 32'd0);
    @(negedge clk); chk("pc_step1", dut.pc_q, 32'd4);
    @(negedge clk); chk("pc_step2", dut.pc_q, 32'd8);
    run_to_halt("alu", 50);
    repeat (5) @(negedge clk);
    drain();

    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", dut.pc_q, 32'd0);
    chk("rst_halted", {31'b0, dut.halted}, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.u_rf.regs[i[4:0]] != 32'd0) nz++;
    chk("rst_regs_zero", nz, 32'd0);
    rst = 1'b0;
    @(negedge clk); chk("restart_pc", dut.pc_q, 32'd4);

    foreach (vecs[k]) begin
      li(5'd1, vecs[k].a);
      li(5'd2, vecs[k].b);
      prog.push_back(vecs[k].instr);
      prog.push_back(ECALL);
      load_prog();
      expect_val({"vec_", vecs[k].name}, K_REG, 3, vecs[k].exp);
      do_reset();
      run_to_halt(vecs[k].name, 30);
      drain();
    end

    // loads/stores: lanes, extension, alignment masking, address wrap
    prog.push_back(enc_u(20'h12345, 5'd6, T_LUI));
    prog.push_back(enc_i(12'h678, 5'd6, 3'b000, 5'd6, T_IMM));
    prog.push_back(enc_s(12'd8, 5'd6, 5'd0, 3'b010));
    prog.push_back(enc_i(12'd9, 5'd0, 3'b000, 5'd7, T_LD));
    prog.push_back(enc_i(12'd10, 5'd0, 3'b101, 5'd8, T_LD));
    prog.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd2, T_IMM));
    prog.push_back(enc_s(12'd11, 5'd2, 5'd0, 3'b000));
    prog.push_back(enc_i(12'd8, 5'd0, 3'b010, 5'd9, T_LD));
    prog.push_back(enc_i(12'hF80, 5'd0, 3'b000, 5'd11, T_IMM));
    prog.push_back(enc_s(12'd12, 5'd0, 5'd0, 3'b010));
    prog.push_back(enc_s(12'd12, 5'd11, 5'd0, 3'b000));
    prog.push_back(enc_s(12'd14, 5'd11, 5'd0, 3'b001));
    prog.push_back(enc_i(12'd12, 5'd0, 3'b010, 5'd15, T_LD));
    prog.push_back(enc_i(12'd14, 5'd0, 3'b001, 5'd14, T_LD));
    prog.push_back(enc_i(12'd12, 5'd0, 3'b100, 5'd13, T_LD));
    prog.push_back(enc_i(12'd12, 5'd0, 3'b000, 5'd12, T_LD));
    prog.push_back(enc_i(12'd13, 5'd0, 3'b010, 5'd16, T_LD));
    prog.push_back(enc_i(12'h408, 5'd0, 3'b010, 5'd17, T_LD));
    prog.push_back(enc_s(12'd16, 5'd0, 5'd0, 3'b010));
    prog.push_back(enc_i(12'd15, 5'd0, 3'b101, 5'd18, T_LD));
    prog.push_back(ECALL);
    load_prog();
    expect_val("mem_lb",    K_REG, 7,  32'h0000_0056);
    expect_val("mem_lhu",   K_REG, 8,  32'h0000_1234);
    expect_val("mem_lw_sb", K_REG, 9,  32'h0334_5678);
    expect_val("mem_lb_sx", K_REG, 12, 32'hFFFF_FF80);
    expect_val("mem_lbu",   K_REG, 13, 32'h0000_0080);
    expect_val("mem_lh_sx", K_REG, 14, 32'hFFFF_FF80);
    expect_val("mem_sh_sb", K_REG, 15, 32'hFF80_0080);
    expect_val("mem_lw_al", K_REG, 16, 32'hFF80_0080);
    expect_val("mem_wrap",  K_REG, 17, 32'h0334_5678);
    expect_val("mem_lh_al", K_REG, 18, 32'h0000_FF80);
    expect_val("mem_byte11", K_MEMB, 11, 32'h0000_0003);
    expect_val("mem_w16",   K_MEMW, 16, 32'h0);
    do_reset();
    run_to_halt("mem", 60);
    drain();
    do_reset();
    chk("dmem_kept", observe(K_MEMW, 8), 32'h0334_5678);

    // control flow
    prog.push_back(enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, T_IMM));
    prog.push_back(enc_i(12'd3, 5'd0, 3'b000, 5'd2, T_IMM));
    prog.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd20, T_IMM));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b110));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd21, T_IMM));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b100));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd24, T_IMM));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b101));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd25, T_IMM));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'b111));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd26, T_IMM));
    prog.push_back(enc_j(21'd12, 5'd1));
    prog.push_back(enc_j(21'd16, 5'd0));
    prog.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd22, T_IMM));
    prog.push_back(enc_i(12'd5, 5'd0, 3'b000, 5'd23, T_IMM));
    prog.push_back(enc_i(12'd1, 5'd1, 3'b000, 5'd0, T_JALR));
    prog.push_back(enc_i(12'd0, 5'd0, 3'b000, 5'd10, T_IMM));
    prog.push_back(enc_i(12'd10, 5'd0, 3'b000, 5'd11, T_IMM));
    prog.push_back(enc_i(12'd1, 5'd10, 3'b000, 5'd10, T_IMM));
    prog.push_back(enc_b(13'h1FFC, 5'd11, 5'd10, 3'b001));
    prog.push_back(ECALL);
    load_prog();
    expect_val("beq_skip",   K_REG, 20, 32'd0);
    expect_val("bltu_fall",  K_REG, 21, 32'd1);
    expect_val("blt_skip",   K_REG, 24, 32'd0);
    expect_val("bge_fall",   K_REG, 25, 32'd1);
    expect_val("bgeu_skip",  K_REG, 26, 32'd0);
    expect_val("jal_link",   K_REG, 1,  32'd52);
    expect_val("jal_skip",   K_REG, 22, 32'd0);
    expect_val("jal_target", K_REG, 23, 32'd5);
    expect_val("loop_cnt",   K_REG, 10, 32'd10);
    expect_val("ctl_pc",     K_PC,  0,  32'd84);
    do_reset();
    run_to_halt("ctl", 200);
    drain();

    // reset on the same edge as a store
    prog.push_back(enc_i(12'h055, 5'd0, 3'b000, 5'd5, T_IMM));
    prog.push_back(enc_s(12'd16, 5'd5, 5'd0, 3'b010));
    prog.push_back(ECALL);
    load_prog();
    do_reset();
    @(negedge clk);
    chk("mid_pc_at_sw", dut.pc_q, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pc_reset", dut.pc_q, 32'd0);
    chk("mid_store_blocked", observe(K_MEMW, 16), 32'h0);
    rst = 1'b0;
    expect_val("mid_store_after", K_MEMW, 16, 32'h0000_0055);
    run_to_halt("mid", 20);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
